wave_gen: RTL and testbench

Register-programmed waveform generator that sits directly downstream of the UART register FSM in dig_core. It consumes byte-wide register writes and produces an 8-bit DAC sample stream on dac_o. A phase accumulator advances on a prescaled sample tick and addresses a shape generator, which is followed by an amplitude scaler. The block is a 2-stage pipeline.

---
 rtl/wave_gen.sv | 176 +++++++++++++++++
 tb/tb_wave_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen.sv
// rtl/wave_gen.sv - register-programmed waveform generator; WAVE_SINE_EN enables the sine shape on code 3
module wave_gen #(
  parameter int ACC_W      = 24,
  parameter int SAMPLE_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [2:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] dac_o,
  output logic       dac_valid_o,
  output logic       wrap_o,
  output logic       run_o
);

  localparam int               CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  localparam logic [2:0] A_FREQ0  = 3'd0;
  localparam logic [2:0] A_FREQ1  = 3'd1;
  localparam logic [2:0] A_FREQ2  = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;
  localparam logic [2:0] A_AMP    = 3'd4;
  localparam logic [2:0] A_COMMIT = 3'd5;

`ifdef WAVE_SINE_EN
  // Quarter-wave magnitude table: round(127 * sin(pi/2 * i/63)), so the last entry is the full peak.
  localparam logic [7:0] SINE_Q [64] = '{
    8'd0,   8'd3,   8'd6,   8'd9,   8'd13,  8'd16,  8'd19,  8'd22,
    8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
    8'd49,  8'd52,  8'd55,  8'd58,  8'd61,  8'd64,  8'd66,  8'd69,
    8'd72,  8'd74,  8'd77,  8'd79,  8'd82,  8'd84,  8'd86,  8'd89,
    8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
    8'd107, 8'd108, 8'd110, 8'd112, 8'd113, 8'd114, 8'd116, 8'd117,
    8'd118, 8'd119, 8'd120, 8'd121, 8'd122, 8'd123, 8'd124, 8'd124,
    8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd127
  };
`endif

  logic [23:0]      stage_q;
  logic [ACC_W-1:0] staged_word;
  logic [ACC_W-1:0] active_word;
  logic [ACC_W-1:0] phase;
  logic [1:0]       shape_q;
  logic             run_q;
  logic             run_d;
  logic [7:0]       amp_q;
  logic             commit_pending;
  logic [CNT_W-1:0] div_cnt;
  logic [7:0]       s1_q;
  logic             s1_valid;
  logic             tick;
  logic             wrap_evt;
  logic             stop_evt;
  logic             apply;
  logic             wr_commit;
  logic [ACC_W:0]   sum;
  logic [15:0]      amp_p1;
  logic [15:0]      prod;

  // Only the tuning-word bytes that fit inside the accumulator are kept.
  if (ACC_W > 24) begin : g_wide
    assign staged_word = {{(ACC_W-24){1'b0}}, stage_q};
  end else begin : g_narrow
    assign staged_word = stage_q[ACC_W-1:0];
  end

  assign run_o     = run_q;
  assign tick      = run_q && (div_cnt == CNT_LAST);
  assign sum       = {1'b0, phase} + {1'b0, active_word};
  assign wrap_evt  = tick && sum[ACC_W];
  assign stop_evt  = run_d && !run_q;
  assign wr_commit = wr_en_i && (wr_addr_i == A_COMMIT);
  // A pending word lands only on a phase wrap (or immediately while stopped) so no period is cut short.
  assign apply     = commit_pending && (wrap_evt || !run_q);
  assign amp_p1    = {8'd0, amp_q} + 16'd1;
  assign prod      = {8'd0, s1_q} * amp_p1;

  function automatic logic [7:0] shape_sample(input logic [1:0] sh, input logic [7:0] p);
    logic [7:0] r;
    case (sh)
      2'd0:    r = p[7] ? 8'h00 : 8'hFF;
      2'd1:    r = p;
      2'd2:    r = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
`ifdef WAVE_SINE_EN
      default: begin
        logic [5:0] idx;
        idx = p[6] ? ~p[5:0] : p[5:0];
        r   = p[7] ? (8'h80 - SINE_Q[idx]) : (8'h80 + SINE_Q[idx]);
      end
`else
      default: r = 8'hFF;
`endif
    endcase
    return r;
  endfunction

  // Register writes and the staged-to-active tuning word handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q        <= '0;
      active_word    <= '0;
      shape_q        <= '0;
      run_q          <= 1'b0;
      amp_q          <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (wr_en_i) begin
        case (wr_addr_i)
          A_FREQ0: stage_q[7:0]   <= wr_data_i;
          A_FREQ1: stage_q[15:8]  <= wr_data_i;
          A_FREQ2: stage_q[23:16] <= wr_data_i;
          A_CTRL: begin
            shape_q <= wr_data_i[1:0];
            run_q   <= wr_data_i[7];
          end
          A_AMP:   amp_q <= wr_data_i;
          default: ;
        endcase
      end
      if (apply) active_word <= staged_word;
      // A fresh COMMIT always leaves a request pending, even when it coincides with a wrap.
      if (wr_commit)  commit_pending <= 1'b1;
      else if (apply) commit_pending <= 1'b0;
    end
  end

  // Sample-tick prescaler and phase accumulator; both park at zero while stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= '0;
      run_d   <= 1'b0;
      wrap_o  <= 1'b0;
    end else begin
      run_d  <= run_q;
      wrap_o <= wrap_evt;
      if (!run_q) begin
        div_cnt <= '0;
        phase   <= '0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) phase <= sum[ACC_W-1:0];
      end
    end
  end

  // Stage 1 shapes the advanced phase; a stop injects one zero sample to park the DAC at 0x00.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
    end else if (tick) begin
      s1_q     <= shape_sample(shape_q, sum[ACC_W-1 -: 8]);
      s1_valid <= 1'b1;
    end else if (stop_evt) begin
      s1_q     <= '0;
      s1_valid <= 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 scales by (AMP+1)/256 so full amplitude is an exact pass-through.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_o       <= '0;
      dac_valid_o <= 1'b0;
    end else begin
      dac_valid_o <= s1_valid;
      if (s1_valid) dac_o <= prod[15:8];
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// tb/tb_wave_gen.sv - scoreboard bench for wave_gen
module tb_wave_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       slow_only;
  logic       slow_chk = 1'b0;
  logic       wr_en_f;

  logic [7:0] dac_f, dac_s;
  logic       vld_f, vld_s, wrap_f, wrap_s, run_f, run_s;

  always #5 clk = ~clk;

  assign wr_en_f = wr_en && !slow_only;

  wave_gen #(.ACC_W(24), .SAMPLE_DIV(1)) u_fast (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_f), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .dac_o(dac_f), .dac_valid_o(vld_f), .wrap_o(wrap_f), .run_o(run_f)
  );

  wave_gen #(.ACC_W(24), .SAMPLE_DIV(50)) u_slow (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .dac_o(dac_s), .dac_valid_o(vld_s), .wrap_o(wrap_s), .run_o(run_s)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_total = 0;
  int exp_q[$];
  int wrap_log[$];
  int slow_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Fast-instance monitor: every DAC update pops one expected sample.
  always @(negedge clk) begin
    if (vld_f === 1'b1) begin
      vld_total++;
      if (exp_q.size() == 0) check("fast_unexpected_valid", 32'd1, 32'd0);
      else                   check("fast_dac", dac_f, exp_q.pop_front());
    end
    if (wrap_f === 1'b1) wrap_log.push_back(vld_total);
  end

  // Slow-instance monitor: each DAC update must land on its predicted cycle.
  always @(negedge clk) begin
    if (slow_chk && vld_s === 1'b1) begin
      if (slow_cyc_q.size() == 0) check("slow_unexpected_valid", 32'd1, 32'd0);
      else begin
        check("slow_valid_cycle", cyc, slow_cyc_q.pop_front());
        check("slow_dac", dac_s, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input string name, input int n);
    repeat (n) step();
    check(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w;
    int wexp[5];
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; slow_only = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_dac", dac_f, 32'h00);
    check("reset_valid", vld_f, 32'd0);
    check("reset_wrap", wrap_f, 32'd0);
    check("reset_run", run_f, 32'd0);
    check("reset_slow_dac", dac_s, 32'h00);

    // Saw, step 1 per tick, full amplitude; 520 ticks then stop.
    wr(3'd0, 8'h00); wr(3'd1, 8'h00); wr(3'd2, 8'h01); wr(3'd5, 8'h00); wr(3'd4, 8'hFF);
    for (int k = 1; k <= 520; k++) exp_q.push_back(k % 256);
    exp_q.push_back(0);
    wr(3'd3, 8'h81);
    w = cyc;
    check("saw_run_on", run_f, 32'd1);
    go_to(w + 519);
    wr(3'd3, 8'h01);
    drain("saw_drain", 10);
    check("saw_run_off", run_f, 32'd0);
    check("saw_wrap_count", wrap_log.size(), 32'd2);
    wexp[0] = 255; wexp[1] = 511;
    for (int i = 0; i < 2 && i < wrap_log.size(); i++) check("saw_wrap_pos", wrap_log[i], wexp[i]);

    // Glitch-free commit: step 1 -> 2 at the first wrap; a COMMIT on the wrap cycle waits a full period.
    for (int k = 1; k <= 256; k++) exp_q.push_back(k % 256);
    for (int k = 257; k <= 512; k++) exp_q.push_back((2 * (k - 256)) % 256);
    for (int k = 513; k <= 600; k++) exp_q.push_back(k - 512);
    exp_q.push_back(0);
    wr(3'd3, 8'h81);
    w = cyc;
    go_to(w + 99);  wr(3'd2, 8'h02); wr(3'd5, 8'h00);
    go_to(w + 299); wr(3'd2, 8'h01);
    go_to(w + 383); wr(3'd5, 8'h00);
    go_to(w + 599); wr(3'd3, 8'h01);
    drain("commit_drain", 10);
    check("commit_wrap_count", wrap_log.size(), 32'd5);
    wexp[2] = 776; wexp[3] = 904; wexp[4] = 1032;
    for (int i = 0; i < 5 && i < wrap_log.size(); i++) check("commit_wrap_pos", wrap_log[i], wexp[i]);

    // Triangle at AMP=0x7F: output is half the triangle sample (0x40 at p=0x40).
    wr(3'd4, 8'h7F);
    for (int k = 1; k <= 200; k++) exp_q.push_back(k < 128 ? k : 255 - k);
    exp_q.push_back(0);
    wr(3'd3, 8'h82);
    w = cyc;
    go_to(w + 199); wr(3'd3, 8'h02);
    drain("tri_drain", 10);

    // Square at AMP=0x00: output pinned at zero.
    wr(3'd4, 8'h00);
    for (int k = 0; k <= 50; k++) exp_q.push_back(0);
    wr(3'd3, 8'h80);
    w = cyc;
    go_to(w + 49); wr(3'd3, 8'h00);
    drain("square_drain", 10);

`ifdef WAVE_SINE_EN
    // Sine at quarter-turn steps: p = 0x40, 0x80, 0xC0, 0x00, ...
    wr(3'd4, 8'hFF); wr(3'd2, 8'h40); wr(3'd5, 8'h00);
    for (int k = 1; k <= 8; k++) exp_q.push_back((k % 4 == 1) ? 'hFF : ((k % 4 == 3) ? 'h01 : 'h80));
    exp_q.push_back(0);
    wr(3'd3, 8'h83);
    w = cyc;
    go_to(w + 7); wr(3'd3, 8'h03);
    drain("sine_drain", 10);
`else
    // Shape 3 is DC full-scale, so the output equals AMP.
    wr(3'd4, 8'h90);
    for (int k = 1; k <= 20; k++) exp_q.push_back('h90);
    exp_q.push_back(0);
    wr(3'd3, 8'h83);
    w = cyc;
    go_to(w + 19); wr(3'd3, 8'h03);
    drain("dc_drain", 10);
`endif

    // Reset held 3 cycles mid-run; a run write during reset must be lost.
    wr(3'd4, 8'hFF); wr(3'd2, 8'h01); wr(3'd5, 8'h00);
    for (int k = 1; k <= 28; k++) exp_q.push_back(k);
    wr(3'd3, 8'h81);
    w = cyc;
    go_to(w + 29);
    rst = 1'b1;
    step();
    step();
    wr(3'd3, 8'h81);
    rst = 1'b0;
    step();
    check("rst_dac", dac_f, 32'h00);
    check("rst_run", run_f, 32'd0);
    check("rst_wrap", wrap_f, 32'd0);
    check("rst_valid", vld_f, 32'd0);
    drain("rst_drain", 20);
    check("rst_run_still_off", run_f, 32'd0);

    // Prescaler on the SAMPLE_DIV=50 instance: first update 51 cycles after the run write, then every 50.
    slow_only = 1'b1;
    slow_chk  = 1'b1;
    w = cyc + 1;
    slow_cyc_q.push_back(w + 51);
    slow_cyc_q.push_back(w + 101);
    slow_cyc_q.push_back(w + 151);
    slow_cyc_q.push_back(w + 201);
    slow_cyc_q.push_back(w + 212);
    wr(3'd3, 8'h81);
    check("slow_run_on", run_s, 32'd1);
    go_to(w + 209);
    wr(3'd3, 8'h01);
    repeat (120) step();
    check("slow_drain", slow_cyc_q.size(), 32'd0);
    check("slow_run_off", run_s, 32'd0);
    check("fast_idle_during_slow", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
